// File: rtl/trigger_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_wb_pkg
// Description : Shared types and constants for the trigger-chain Wishbone
//               fan-out (FSM states, response kinds, channel address stride).
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        R_ACK = 2'd0,
        R_ERR = 2'd1,
        R_RTY = 2'd2
    } resp_t;

    // Address distance between consecutive channel register windows.
    localparam int CHAN_STRIDE = 'h400;

endpackage
`default_nettype wire

// File: rtl/wb_resp_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_resp_mux
// Description : NCHAN-to-1 combinational selection of the downstream
//               ack/err/rty/data of the currently addressed channel.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_resp_mux #(
    parameter int NCHAN     = 8,
    parameter int DAT_W     = 32,
    parameter int CHAN_BITS = 3
) (
    input  logic [CHAN_BITS-1:0]   i_ch,
    input  logic [NCHAN-1:0]       i_ack,
    input  logic [NCHAN-1:0]       i_err,
    input  logic [NCHAN-1:0]       i_rty,
    input  logic [NCHAN*DAT_W-1:0] i_dat,
    output logic                   o_ack,
    output logic                   o_err,
    output logic                   o_rty,
    output logic [DAT_W-1:0]       o_dat
);

    // An index outside 0..NCHAN-1 matches nothing and yields all zeros.
    always_comb begin
        o_ack = 1'b0;
        o_err = 1'b0;
        o_rty = 1'b0;
        o_dat = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (i_ch == CHAN_BITS'(c)) begin
                o_ack = i_ack[c];
                o_err = i_err[c];
                o_rty = i_rty[c];
                o_dat = i_dat[c*DAT_W +: DAT_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_chan_fanout.sv
`default_nettype none
// ============================================================================
// Module      : wb_chan_fanout
// Description : Registered Wishbone fan-out to NCHAN trigger-chain channels,
//               one transaction at a time, with decode-error and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_chan_fanout
    import trigger_wb_pkg::*;
#(
    parameter int NCHAN     = 8,
    parameter int ADR_W     = 22,
    parameter int DAT_W     = 32,
    parameter int CHAN_LSB  = 10,
    parameter int CHAN_BITS = 3,
    parameter int SUB_ADR_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [ADR_W-1:0]       wb_adr_i,
    input  logic [DAT_W-1:0]       wb_dat_i,
    input  logic [DAT_W/8-1:0]     wb_sel_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic [DAT_W-1:0]       wb_dat_o,
    output logic [NCHAN-1:0]       m_cyc_o,
    output logic [NCHAN-1:0]       m_stb_o,
    output logic                   m_we_o,
    output logic [SUB_ADR_W-1:0]   m_adr_o,
    output logic [DAT_W-1:0]       m_dat_o,
    output logic [DAT_W/8-1:0]     m_sel_o,
    input  logic [NCHAN-1:0]       m_ack_i,
    input  logic [NCHAN-1:0]       m_err_i,
    input  logic [NCHAN-1:0]       m_rty_i,
    input  logic [NCHAN*DAT_W-1:0] m_dat_i,
    output logic [15:0]            err_cnt_o,
    output logic                   timeout_o
);

    localparam int                   c_sel_w   = DAT_W / 8;
    localparam int                   c_tmr_w   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CHAN_BITS:0]   c_nchan   = (CHAN_BITS + 1)'(NCHAN);
    localparam logic [c_tmr_w-1:0]   c_timeout = c_tmr_w'(TIMEOUT);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CHAN_BITS-1:0]   r_ch;
    logic [c_tmr_w-1:0]     r_timer;
    logic [c_tmr_w-1:0]     w_timer_nxt;
    logic                   r_we;
    logic [SUB_ADR_W-1:0]   r_adr;
    logic [DAT_W-1:0]       r_dat;
    logic [c_sel_w-1:0]     r_sel;
    logic [NCHAN-1:0]       r_mcyc;
    logic                   r_ack;
    logic                   r_err;
    logic                   r_rty;
    logic [DAT_W-1:0]       r_rdat;
    logic [15:0]            r_err_cnt;
    logic                   r_tmo;

    logic [CHAN_BITS-1:0]   w_ch_in;
    logic [CHAN_BITS-1:0]   w_ch_nxt;
    logic                   w_ch_bad;
    logic                   w_latch;
    logic                   w_enter_resp;
    resp_t                  w_resp;
    logic [DAT_W-1:0]       w_rdat;
    logic                   w_tmo;
    logic                   w_cnt_inc;
    logic [NCHAN-1:0]       w_mcyc_nxt;
    logic                   w_sel_ack;
    logic                   w_sel_err;
    logic                   w_sel_rty;
    logic [DAT_W-1:0]       w_sel_dat;
    logic                   w_unused_adr;

    assign w_ch_in      = wb_adr_i[CHAN_LSB +: CHAN_BITS];
    assign w_ch_bad     = {1'b0, w_ch_in} >= c_nchan;
    assign w_ch_nxt     = w_latch ? w_ch_in : r_ch;
    assign w_unused_adr = ^wb_adr_i;

    wb_resp_mux #(
        .NCHAN     (NCHAN),
        .DAT_W     (DAT_W),
        .CHAN_BITS (CHAN_BITS)
    ) u_resp_mux (
        .i_ch  (r_ch),
        .i_ack (m_ack_i),
        .i_err (m_err_i),
        .i_rty (m_rty_i),
        .i_dat (m_dat_i),
        .o_ack (w_sel_ack),
        .o_err (w_sel_err),
        .o_rty (w_sel_rty),
        .o_dat (w_sel_dat)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_latch      = 1'b0;
        w_enter_resp = 1'b0;
        w_resp       = R_ACK;
        w_rdat       = '0;
        w_tmo        = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    w_latch = 1'b1;
                    if (w_ch_bad) begin
                        w_resp       = R_ERR;
                        w_cnt_inc    = 1'b1;
                        w_enter_resp = 1'b1;
                        w_state_nxt  = RESP;
                    end else begin
                        w_timer_nxt = '0;
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                // A real response beats a timeout expiring in the same cycle.
                if (!wb_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (w_sel_err || w_sel_rty || w_sel_ack) begin
                    w_enter_resp = 1'b1;
                    w_state_nxt  = RESP;
                    if (w_sel_err) begin
                        w_resp = R_ERR;
                    end else if (w_sel_rty) begin
                        w_resp = R_RTY;
                    end else begin
                        w_resp = R_ACK;
                        w_rdat = w_sel_dat;
                    end
                end else if ((TIMEOUT != 0) && (r_timer == c_timeout)) begin
                    w_resp       = R_ERR;
                    w_tmo        = 1'b1;
                    w_cnt_inc    = 1'b1;
                    w_enter_resp = 1'b1;
                    w_state_nxt  = RESP;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    generate
        for (genvar c = 0; c < NCHAN; c++) begin : g_chan_sel
            assign w_mcyc_nxt[c] = (w_state_nxt == BUSY) && (w_ch_nxt == CHAN_BITS'(c));
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ch      <= '0;
            r_timer   <= '0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_mcyc    <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rty     <= 1'b0;
            r_rdat    <= '0;
            r_err_cnt <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_timer <= w_timer_nxt;
            r_mcyc  <= w_mcyc_nxt;
            if (w_latch) begin
                r_ch  <= w_ch_in;
                r_we  <= wb_we_i;
                r_adr <= wb_adr_i[SUB_ADR_W-1:0];
                r_dat <= wb_dat_i;
                r_sel <= wb_sel_i;
            end
            r_ack  <= w_enter_resp && (w_resp == R_ACK);
            r_err  <= w_enter_resp && (w_resp == R_ERR);
            r_rty  <= w_enter_resp && (w_resp == R_RTY);
            r_rdat <= w_rdat;
            r_tmo  <= w_tmo;
            if (w_cnt_inc && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign wb_rty_o  = r_rty;
    assign wb_dat_o  = r_rdat;
    assign m_cyc_o   = r_mcyc;
    assign m_stb_o   = r_mcyc;
    assign m_we_o    = r_we;
    assign m_adr_o   = r_adr;
    assign m_dat_o   = r_dat;
    assign m_sel_o   = r_sel;
    assign err_cnt_o = r_err_cnt;
    assign timeout_o = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_wb_chan_fanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_chan_fanout
// Description : Scoreboard bench for wb_chan_fanout with a behavioural
//               channel responder and noise on non-selected channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_chan_fanout;
    import trigger_wb_pkg::*;

    localparam int NCHAN     = 6;
    localparam int ADR_W     = 22;
    localparam int DAT_W     = 32;
    localparam int SEL_W     = DAT_W / 8;
    localparam int CHAN_LSB  = 10;
    localparam int CHAN_BITS = 3;
    localparam int SUB_ADR_W = 8;
    localparam int TIMEOUT   = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   wb_rst_i = 1'b1;
    logic                   wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [ADR_W-1:0]       wb_adr_i = '0;
    logic [DAT_W-1:0]       wb_dat_i = '0;
    logic [SEL_W-1:0]       wb_sel_i = '0;
    logic                   wb_ack_o, wb_err_o, wb_rty_o;
    logic [DAT_W-1:0]       wb_dat_o;
    logic [NCHAN-1:0]       m_cyc_o, m_stb_o;
    logic                   m_we_o;
    logic [SUB_ADR_W-1:0]   m_adr_o;
    logic [DAT_W-1:0]       m_dat_o;
    logic [SEL_W-1:0]       m_sel_o;
    logic [NCHAN-1:0]       m_ack_i = '0, m_err_i = '0, m_rty_i = '0;
    logic [NCHAN*DAT_W-1:0] m_dat_i = '0;
    logic [15:0]            err_cnt_o;
    logic                   timeout_o;

    wb_chan_fanout #(
        .NCHAN(NCHAN), .ADR_W(ADR_W), .DAT_W(DAT_W), .CHAN_LSB(CHAN_LSB),
        .CHAN_BITS(CHAN_BITS), .SUB_ADR_W(SUB_ADR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .wb_dat_o(wb_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
        .m_dat_i(m_dat_i),
        .err_cnt_o(err_cnt_o), .timeout_o(timeout_o)
    );

    typedef struct {
        resp_t       kind;
        logic [31:0] data;
        int          cyc;
        logic        tmo;
        logic [15:0] errcnt;
    } exp_t;

    exp_t        q[$];
    exp_t        m_item;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc_cnt  = 0;
    logic [15:0] exp_err  = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    function automatic logic [2:0] kind_bits(input resp_t k);
        case (k)
            R_ERR:   return 3'b010;
            R_RTY:   return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // Monitor: every upstream response is matched against the oldest expectation.
    always @(negedge clk) begin
        check("cyc_onehot0", 64'($onehot0(m_cyc_o)), 64'd1);
        if (timeout_o) check("timeout_with_err", 64'(wb_err_o), 64'd1);
        if (wb_ack_o || wb_err_o || wb_rty_o) begin
            if (q.size() == 0) begin
                check("unexpected_resp", 64'({wb_rty_o, wb_err_o, wb_ack_o}), 64'd0);
            end else begin
                m_item = q.pop_front();
                check("resp_kind", 64'({wb_rty_o, wb_err_o, wb_ack_o}), 64'(kind_bits(m_item.kind)));
                check("resp_data", 64'(wb_dat_o), 64'(m_item.data));
                check("resp_cycle", 64'(cyc_cnt), 64'(m_item.cyc));
                check("timeout_pulse", 64'(timeout_o), 64'(m_item.tmo));
                check("err_cnt", 64'(err_cnt_o), 64'(m_item.errcnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_noise(input int ch);
        for (int c = 0; c < NCHAN; c++) begin
            m_dat_i[c*DAT_W +: DAT_W] = $urandom;
            m_ack_i[c] = (c == ch) ? 1'b0 : 1'($urandom);
            m_err_i[c] = (c == ch) ? 1'b0 : 1'($urandom);
            m_rty_i[c] = (c == ch) ? 1'b0 : 1'($urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp"}, 64'({wb_ack_o, wb_err_o, wb_rty_o, timeout_o, m_we_o}), 64'd0);
        check({tag, "_wb_dat"}, 64'(wb_dat_o), 64'd0);
        check({tag, "_m_cyc_stb"}, 64'({m_cyc_o, m_stb_o}), 64'd0);
        check({tag, "_m_adr_sel"}, 64'({m_adr_o, m_sel_o}), 64'd0);
        check({tag, "_m_dat"}, 64'(m_dat_o), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt_o), 64'd0);
    endtask

    // rsp = {rty,err,ack} driven by the selected channel; 0 means it never answers.
    task automatic xfer(input int ch, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, input logic [7:0] sub,
                        input logic [2:0] rsp, input int dly, input logic [31:0] rdat);
        exp_t             e;
        logic [NCHAN-1:0] oh;
        int               t;
        bit               dec_err, tmo;
        dec_err = (ch >= NCHAN);
        tmo     = !dec_err && ((rsp == 3'b000) || (dly > TIMEOUT));
        e.tmo   = tmo;
        e.data  = '0;
        if (dec_err || tmo) begin
            e.kind  = R_ERR;
            exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
        end else if (rsp[1]) e.kind = R_ERR;
        else if (rsp[2])     e.kind = R_RTY;
        else begin
            e.kind = R_ACK;
            e.data = rdat;
        end
        e.errcnt = exp_err;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = ADR_W'(ch * CHAN_STRIDE) | ADR_W'(sub);
        wb_dat_i = wdat; wb_sel_i = sel;
        tick();
        e.cyc = dec_err ? cyc_cnt : (tmo ? cyc_cnt + TIMEOUT + 1 : cyc_cnt + dly + 1);
        q.push_back(e);
        if (dec_err) begin
            check("decode_no_cyc", 64'(m_cyc_o), 64'd0);
        end else begin
            oh = '0;
            oh[ch] = 1'b1;
            check("m_cyc", 64'(m_cyc_o), 64'(oh));
            check("m_stb", 64'(m_stb_o), 64'(oh));
            check("m_fields", {m_we_o, m_adr_o, m_sel_o, m_dat_o}, {we, sub, sel, wdat});
        end
        if (!dec_err && !tmo) begin
            for (int i = 0; i < dly; i++) begin
                drive_noise(ch);
                tick();
            end
            drive_noise(ch);
            {m_rty_i[ch], m_err_i[ch], m_ack_i[ch]} = rsp;
            m_dat_i[ch*DAT_W +: DAT_W] = rdat;
            tick();
        end
        t = 0;
        while (!(wb_ack_o || wb_err_o || wb_rty_o) && (t < TIMEOUT + 20)) begin
            drive_noise(ch);
            tick();
            t++;
        end
        if (t >= TIMEOUT + 20) begin
            check("resp_wait_expired", 64'd0, 64'd1);
            q.delete();
        end else if (!dec_err) begin
            check("m_cyc_drop", 64'(m_cyc_o), 64'd0);
        end
        m_ack_i = '0; m_err_i = '0; m_rty_i = '0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] r;
        repeat (3) tick();
        check_all_zero("reset");
        wb_rst_i = 1'b0;
        tick();

        xfer(5, 1'b0, 32'h0, 4'h0, 8'h04, 3'b001, 1, 32'hDEADBEEF);   // read ch5
        xfer(6, 1'b1, 32'h1234_5678, 4'hF, 8'h00, 3'b001, 0, 32'h0); // decode error
        xfer(2, 1'b0, 32'h0, 4'hF, 8'h20, 3'b000, 0, 32'h0);          // timeout
        xfer(3, 1'b0, 32'h0, 4'hF, 8'h30, 3'b011, 0, 32'hCAFE_F00D);  // ack+err -> err
        xfer(0, 1'b1, 32'hA5A5_5A5A, 4'h3, 8'hFF, 3'b100, 0, 32'h0);  // retry
        xfer(4, 1'b1, 32'h0F0F_0F0F, 4'h9, 8'h11, 3'b101, 2, 32'h0);  // rty beats ack
        xfer(1, 1'b0, 32'h0, 4'hF, 8'h08, 3'b001, TIMEOUT, 32'h7777_1111); // ack ties timeout
        xfer(7, 1'b0, 32'h0, 4'hF, 8'h00, 3'b001, 0, 32'h0);          // decode error ch7

        // Abort: master drops cyc while the channel is still busy.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = ADR_W'(1 * CHAN_STRIDE) | ADR_W'(8'h44);
        tick();
        check("abort_m_cyc", 64'(m_cyc_o), 64'(6'h02));
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        check("abort_drop", 64'({m_cyc_o, m_stb_o}), 64'd0);
        repeat (3) tick();

        // Reset in the middle of a busy transfer.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = ADR_W'(4 * CHAN_STRIDE) | ADR_W'(8'h10);
        wb_dat_i = 32'hFEED_BEEF; wb_sel_i = 4'hF;
        tick();
        tick();
        wb_rst_i = 1'b1;
        tick();
        check_all_zero("rst_busy");
        wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        exp_err = '0;
        tick();

        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 7))
                5:       r = 3'b010;
                6:       r = 3'b100;
                7:       r = 3'($urandom_range(1, 7));
                default: r = 3'b001;
            endcase
            xfer($urandom_range(0, 7), 1'($urandom), $urandom, 4'($urandom),
                 8'($urandom), r, $urandom_range(0, TIMEOUT - 1), $urandom);
        end

        repeat (4) tick();
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
